// File: rtl/button_input_reader_pkg.sv
// Address map and bus constants for the button input peripheral.
// Shared by the top level and the testbench.
package button_input_reader_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] BTN_BASE_ADDR = 32'h7000_0000;

  localparam logic [1:0] OFF_LEVEL = 2'd0;
  localparam logic [1:0] OFF_EDGE  = 2'd1;
  localparam logic [1:0] OFF_MASK  = 2'd2;
  localparam logic [1:0] OFF_RSVD  = 2'd3;

  function automatic logic win_hit(
    input logic [31:0] addr,
    input logic [31:0] base
  );
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/button_input_reader_debouncer.sv
// One button: two-flop synchroniser followed by a stability counter.
// rise_o pulses in the cycle the debounced level is about to go 0->1.
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
    end
  end

  // Any sample that agrees with the level restarts the count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/button_input_reader.sv
// Memory-mapped button reader: debounced levels, sticky rising edges,
// interrupt mask and a registered read port on the data bus.
module button_input_reader
  import button_input_reader_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] BASE_ADDR       = BTN_BASE_ADDR
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  input  logic [NUM_BTN-1:0] buttons_i,
  output logic               irq_o
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] rise;

  logic [NUM_BTN-1:0] edge_q;
  logic [NUM_BTN-1:0] edge_d;
  logic [NUM_BTN-1:0] mask_q;
  logic [NUM_BTN-1:0] mask_d;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  rdata_d;
  logic               irq_q;
  logic               irq_d;

  logic               hit;
  logic               rd;
  logic               wr;
  logic [1:0]         off;
  logic [NUM_BTN-1:0] wbits;
  logic               unused_bits;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .pin_i  (buttons_i[g]),
      .level_o(level[g]),
      .rise_o (rise[g])
    );
  end

  assign hit   = en_i && win_hit(addr_i, BASE_ADDR);
  assign rd    = hit && !we_i;
  assign wr    = hit && we_i;
  assign off   = addr_i[3:2];
  assign wbits = wdata_i[NUM_BTN-1:0];

  assign unused_bits = ^{addr_i[1:0], wdata_i};

  // A new rising edge beats a same-cycle W1C on that bit
  always_comb begin
    edge_d = edge_q;
    mask_d = mask_q;
    if (wr) begin
      unique case (off)
        OFF_EDGE: edge_d = edge_q & ~wbits;
        OFF_MASK: mask_d = wbits;
        default:  ;
      endcase
    end
    edge_d = edge_d | rise;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (off)
        OFF_LEVEL: rdata_d = DATA_W'(level);
        OFF_EDGE:  rdata_d = DATA_W'(edge_q);
        OFF_MASK:  rdata_d = DATA_W'(mask_q);
        OFF_RSVD:  rdata_d = '0;
        default:   rdata_d = '0;
      endcase
    end
  end

  assign irq_d = |(edge_q & mask_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_button_input_reader.sv
// Self-checking bench for button_input_reader with a 4-cycle debounce.
// Expected read data is queued when a bus access is issued.
module tb_button_input_reader;
  import button_input_reader_pkg::*;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam logic [31:0] B = 32'h7000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [NB-1:0] btn;
  logic        irq;

  always #5 clk = ~clk;

  button_input_reader #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DC),
    .BASE_ADDR(B)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .rdata_o  (rdata),
    .buttons_i(btn),
    .irq_o    (irq)
  );

  typedef struct {
    logic [31:0] exp;
    string       name;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[12];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp,
                     input string nm);
    exp_t e;
    en = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    e.exp = exp;
    e.name = nm;
    sbq.push_back(e);
    @(negedge clk);
    en = 1'b0;
    we = 1'b0;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_empty: got 0 entries expected 1");
    end else begin
      e = sbq.pop_front();
      chk(e.name, rdata, e.exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic irq_chk(input string nm, input logic exp);
    chk(nm, 32'(irq), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    btn = 4'hF;

    bus(1'b0, B, 0, 0, "rst_rd_level");
    irq_chk("rst_irq", 1'b0);
    bus(1'b0, B + 4, 0, 0, "rst_rd_edge");
    btn = 4'h0;
    bus(1'b0, B + 8, 0, 0, "rst_rd_mask");
    rst = 1'b0;
    idle(3);

    // clean press, level visible 2+DC cycles after the pin change
    btn = 4'b0001;
    for (int j = 0; j < 10; j++)
      bus(1'b0, B, 0, (j >= 2 + DC) ? 32'h1 : 32'h0, "press_lvl");
    bus(1'b0, B + 4, 0, 32'h1, "press_edge");
    irq_chk("press_irq_masked", 1'b0);

    btn = 4'b0011;
    idle(DC - 1);
    btn = 4'b0001;
    idle(10);
    bus(1'b0, B, 0, 32'h1, "glitch_lvl");
    bus(1'b0, B + 4, 0, 32'h1, "glitch_edge");

    btn = 4'b0011;
    idle(10);
    bus(1'b0, B, 0, 32'h3, "stable_lvl");
    bus(1'b0, B + 4, 0, 32'h3, "stable_edge");

    bus(1'b1, B + 4, 32'h1, 0, "w1c_wr");
    bus(1'b0, B + 4, 0, 32'h2, "w1c_edge");

    // write lands on the same edge that sets bit2
    btn = 4'b0111;
    idle(1 + DC);
    bus(1'b1, B + 4, 32'h4, 0, "race_wr");
    bus(1'b0, B + 4, 0, 32'h6, "race_edge");
    bus(1'b0, B, 0, 32'h7, "race_lvl");

    bus(1'b1, B + 4, 32'hF, 0, "clr_all_wr");
    bus(1'b0, B + 4, 0, 32'h0, "clr_all_edge");

    bus(1'b1, B + 8, 32'h2, 0, "mask_wr");
    btn = 4'b0101;
    idle(10);
    irq_chk("irq_release", 1'b0);
    bus(1'b0, B, 0, 32'h5, "fall_lvl");
    bus(1'b0, B + 4, 0, 32'h0, "fall_edge");

    btn = 4'b0111;
    idle(2 + DC);
    irq_chk("irq_pre", 1'b0);
    idle(1);
    irq_chk("irq_set", 1'b1);
    bus(1'b1, B + 4, 32'h2, 0, "irq_w1c_wr");
    irq_chk("irq_hold", 1'b1);
    idle(1);
    irq_chk("irq_clr", 1'b0);

    btn = 4'b0110;
    idle(10);
    btn = 4'b0111;
    idle(10);
    irq_chk("irq_masked", 1'b0);
    bus(1'b0, B + 4, 0, 32'h1, "masked_edge");

    vt[0]  = '{1'b0, 32'h6000_000C, 32'h0, 32'h0, "oow_rd"};
    vt[1]  = '{1'b0, 32'h7000_000C, 32'h0, 32'h0, "rsvd_rd"};
    vt[2]  = '{1'b1, 32'h7000_0000, 32'hF, 32'h0, "lvl_wr"};
    vt[3]  = '{1'b1, 32'h6000_0008, 32'hF, 32'h0, "oow_wr"};
    vt[4]  = '{1'b1, 32'h7000_000C, 32'hF, 32'h0, "rsvd_wr"};
    vt[5]  = '{1'b0, 32'h7000_0000, 32'h0, 32'h7, "lvl_rd"};
    vt[6]  = '{1'b0, 32'h7000_0008, 32'h0, 32'h2, "mask_rd"};
    vt[7]  = '{1'b0, 32'h7000_0004, 32'h0, 32'h1, "edge_rd"};
    vt[8]  = '{1'b0, 32'h7000_0003, 32'h0, 32'h7, "lvl_rd_lowbits"};
    vt[9]  = '{1'b0, 32'h7000_000A, 32'h0, 32'h2, "mask_rd_lowbits"};
    vt[10] = '{1'b1, 32'h7000_0008, 32'hFFFF_FFF1, 32'h0, "mask_wr_hi"};
    vt[11] = '{1'b0, 32'h7000_0008, 32'h0, 32'h1, "mask_trunc"};
    for (int i = 0; i < 12; i++)
      bus(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp, vt[i].name);

    irq_chk("irq_mask_set", 1'b1);
    bus(1'b1, B + 8, 32'h0, 0, "mask_off_wr");
    irq_chk("irq_mask_hold", 1'b1);
    idle(1);
    irq_chk("irq_mask_clr", 1'b0);

    // reset in the middle of a debounce with all buttons held
    btn = 4'b1111;
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    for (int j = 0; j < 10; j++)
      bus(1'b0, B, 0, (j >= 2 + DC) ? 32'hF : 32'h0, "rst_mid_lvl");
    bus(1'b0, B + 4, 0, 32'hF, "rst_mid_edge");
    bus(1'b0, B + 8, 0, 32'h0, "rst_mid_mask");
    irq_chk("rst_mid_irq", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
